cpu_fabric_io_bridge: RTL and testbench
=======================================

Name: cpu_fabric_io_bridge

Overview:
- CPU-side bridge that feeds the west CPU I/O column.
- Takes a 32-bit operand pair from the core's custom-instruction port and streams it nibble-serially onto the OPA_O/OPB_O fabric inputs.
- Then collects the fabric's nibble-serial result from RES0_I, with strobe and flags on RES1_I/RES2_I, and returns a 32-bit result to the core with a valid/ready handshake.

Parameters:
DATA_W, 32, operand/result width; must equal NIB_W*BEATS
NIB_W, 4, nibble width per fabric beat
BEATS, 8, beats per operand/result transfer
TIMEOUT_CYCLES, 255, max WAIT-state cycles before abort (used only with CPU_FABRIC_TIMEOUT_EN)

Ports:
UserCLK  in  1  fabric user clock, rising edge
resetn  in  1  asynchronous active-low reset
cpu_op_valid  in  1  core presents operands
cpu_op_ready  out  1  bridge accepts operands
cpu_op_a  in  DATA_W  operand A
cpu_op_b  in  DATA_W  operand B
cpu_res_valid  out  1  result available
cpu_res_ready  in  1  core consumes result
cpu_res  out  DATA_W  assembled result
cpu_res_flags  out  NIB_W  flags captured from RES2_I
cpu_res_err  out  1  1 = timeout abort
OPA_O  out  NIB_W  operand A nibble to fabric
OPB_O  out  NIB_W  operand B nibble to fabric
RES0_I  in  NIB_W  result nibble from fabric
RES1_I  in  NIB_W  bit0 = result-start strobe; bits[3:1] ignored
RES2_I  in  NIB_W  result flags, sampled on first result beat

Behaviour:
- Reset (async assert, sync release): state IDLE; cpu_op_ready=1; cpu_res_valid=0; cpu_res=0; cpu_res_flags=0; cpu_res_err=0; OPA_O=OPB_O=0; beat counter=0; timeout counter=0.
- FSM states: IDLE, SEND, WAIT, RECV, DONE.
- IDLE:
  - cpu_op_ready=1, and only in IDLE.
  - On cpu_op_valid&&cpu_op_ready: latch A/B into shift registers, beat=0, go to SEND.
- SEND (BEATS cycles):
  - OPA_O/OPB_O driven registered from shift-register LSB nibble, LSB nibble first; beat k carries bits [4k+3:4k].
  - Shift right by NIB_W each cycle.
  - After beat BEATS-1, go to WAIT.
  - First nibble appears on OPA_O the cycle after acceptance.
- Outside SEND, OPA_O=OPB_O=0.
- WAIT:
  - Sample RES1_I[0] each cycle.
  - When it is 1, that same cycle is result beat 0: capture RES0_I into result[3:0], capture RES2_I into flags, beat=1, go to RECV.
  - A strobe during SEND is ignored.
- RECV (BEATS-1 cycles):
  - Capture RES0_I into result nibble 'beat'.
  - RES1_I ignored.
  - After beat BEATS-1, go to DONE.
- DONE:
  - cpu_res_valid=1; cpu_res/flags/err stable.
  - On cpu_res_ready: cpu_res_valid=0, go to IDLE.
  - cpu_op_ready returns to 1 the cycle after the result handshake, so there is no same-cycle overlap.
- Fixed timing: minimum request-to-valid latency is 1 + BEATS + 1 + (BEATS-1) + 1 = 18 cycles (default), including 1 WAIT cycle.
- cpu_res holds its last value after the handshake until the next result completes.
- cpu_op_valid while not in IDLE is ignored; the core must hold its request.
- Reset asserted mid-transfer aborts immediately; partial results are discarded.

Optional Feature:
- Macro CPU_FABRIC_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse without a strobe, go to DONE with cpu_res=0, cpu_res_flags=0, cpu_res_err=1.
  - cpu_res_err clears on the next operand acceptance.
  - The counter resets on entry to WAIT.
- Undefined:
  - WAIT is unbounded.
  - cpu_res_err is tied to 0, and no counter logic exists.

Decomposition:
- Package cpu_fabric_io_pkg: state enum (IDLE, SEND, WAIT, RECV, DONE); DATA_W/NIB_W/BEATS defaults; strobe bit index constant (0).
- One natural sub-module: cpu_fabric_nibble_serdes. It holds the parallel-to-nibble shifter for OPA/OPB and the nibble-to-parallel collector for RES0, and is driven by the FSM's load/shift/capture enables.

Test Plan:
- Loopback, fabric model echoes OPA nibbles onto RES0 with strobe 2 cycles after last send beat, RES2_I=4'hA:
  - A=32'h89ABCDEF, B=32'h01234567 -> OPA_O sequence F,E,D,C,B,A,9,8.
  - OPB_O sequence 7,6,5,4,3,2,1,0.
  - cpu_res=32'h89ABCDEF, flags=4'hA, err=0, valid at cycle 19.
- Back-pressure: cpu_res_ready held low 5 cycles in DONE -> cpu_res_valid stays 1, cpu_res stable; second cpu_op_valid ignored (cpu_op_ready=0) until 1 cycle after handshake.
- Early strobe: RES1_I[0]=1 during SEND beat 3 -> ignored; capture starts only on the first strobe in WAIT.
- Reset mid-RECV: resetn low at beat 4 -> cpu_res_valid=0, OPA_O=0, state IDLE, cpu_op_ready=1 after release; next transaction (A=32'h1, echo) returns 32'h1.
- Timeout (CPU_FABRIC_TIMEOUT_EN, TIMEOUT_CYCLES=16), no strobe -> DONE after 16 WAIT cycles, cpu_res=0, err=1; err clears on next acceptance. Without the macro, the same stimulus leaves the FSM in WAIT indefinitely with err=0.

Source files
------------

// File: rtl/cpu_fabric_io_pkg.sv
// Shared types and defaults for the CPU-to-fabric nibble-serial I/O bridge.
// Optional WAIT timeout is enabled with CPU_FABRIC_TIMEOUT_EN.
package cpu_fabric_io_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int NIB_W_DEF   = 4;
    localparam int BEATS_DEF   = 8;
    localparam int TIMEOUT_DEF = 255;
    localparam int STROBE_BIT  = 0;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_fabric_io_bridge_if.sv
// Core-side operand/result handshake bundle for the fabric I/O bridge.
// master = core, slave = bridge.
interface cpu_fabric_io_bridge_if #(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4
);
    logic              cpu_op_valid;
    logic              cpu_op_ready;
    logic [DATA_W-1:0] cpu_op_a;
    logic [DATA_W-1:0] cpu_op_b;
    logic              cpu_res_valid;
    logic              cpu_res_ready;
    logic [DATA_W-1:0] cpu_res;
    logic [NIB_W-1:0]  cpu_res_flags;
    logic              cpu_res_err;

    modport master (
        output cpu_op_valid, cpu_op_a, cpu_op_b, cpu_res_ready,
        input  cpu_op_ready, cpu_res_valid, cpu_res,
        input  cpu_res_flags, cpu_res_err
    );

    modport slave (
        input  cpu_op_valid, cpu_op_a, cpu_op_b, cpu_res_ready,
        output cpu_op_ready, cpu_res_valid, cpu_res,
        output cpu_res_flags, cpu_res_err
    );
endinterface

// File: rtl/cpu_fabric_nibble_serdes.sv
// Operand nibble serializer and result nibble collector for the bridge.
// Purely enable-driven; sequencing lives in the bridge FSM.
module cpu_fabric_nibble_serdes
    import cpu_fabric_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NIB_W  = NIB_W_DEF,
    parameter int BW     = 3
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              capture,
    input  logic [BW-1:0]     cap_idx,
    input  logic              publish,
    input  logic              clear,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [NIB_W-1:0]  res0,
    output logic [NIB_W-1:0]  opa,
    output logic [NIB_W-1:0]  opb,
    output logic [DATA_W-1:0] res
);

    logic [DATA_W-1:0] sra;
    logic [DATA_W-1:0] srb;
    logic [DATA_W-1:0] col;
    logic [DATA_W-1:0] merged;

    // Final beat is folded in combinationally so res updates with valid.
    always_comb begin
        merged = col;
        merged[int'(cap_idx)*NIB_W +: NIB_W] = res0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sra <= '0;
            srb <= '0;
            col <= '0;
            opa <= '0;
            opb <= '0;
            res <= '0;
        end else begin
            if (load) begin
                opa <= a[NIB_W-1:0];
                opb <= b[NIB_W-1:0];
                sra <= a >> NIB_W;
                srb <= b >> NIB_W;
                col <= '0;
            end else if (shift) begin
                opa <= sra[NIB_W-1:0];
                opb <= srb[NIB_W-1:0];
                sra <= sra >> NIB_W;
                srb <= srb >> NIB_W;
            end else begin
                opa <= '0;
                opb <= '0;
            end
            if (capture)
                col[int'(cap_idx)*NIB_W +: NIB_W] <= res0;
            if (publish)
                res <= merged;
            else if (clear)
                res <= '0;
        end
    end

endmodule

// File: rtl/cpu_fabric_io_bridge.sv
// CPU custom-instruction bridge streaming operands to the west I/O column.
// Define CPU_FABRIC_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module cpu_fabric_io_bridge
    import cpu_fabric_io_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int NIB_W          = NIB_W_DEF,
    parameter int BEATS          = BEATS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
)(
    input  logic                  UserCLK,
    input  logic                  resetn,
    cpu_fabric_io_bridge_if.slave cpu,
    output logic [NIB_W-1:0]      OPA_O,
    output logic [NIB_W-1:0]      OPB_O,
    input  logic [NIB_W-1:0]      RES0_I,
    input  logic [NIB_W-1:0]      RES1_I,
    input  logic [NIB_W-1:0]      RES2_I
);

    localparam int BW = cnt_w(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    state_e           state;
    logic [BW-1:0]    beat;
    logic [NIB_W-1:0] flags_q;
    logic             accept;
    logic             strobe;
    logic             shift;
    logic             capture;
    logic             publish;
    logic             tmo;
    logic [BW-1:0]    cap_idx;
    logic             unused_res1;

    assign unused_res1 = ^RES1_I;

    assign accept  = cpu.cpu_op_ready && cpu.cpu_op_valid;
    assign strobe  = RES1_I[STROBE_BIT];
    assign shift   = (state == SEND) && (beat != LAST);
    assign capture = ((state == WAIT) && strobe) || (state == RECV);
    assign cap_idx = (state == RECV) ? beat : '0;
    assign publish = (state == RECV) && (beat == LAST);

`ifdef CPU_FABRIC_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT_CYCLES);

    logic [TW-1:0] tcnt;
    logic          err_q;

    assign tmo = (state == WAIT) && !strobe &&
                 (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign cpu.cpu_res_err = err_q;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;

    assign tmo = 1'b0;
    assign cpu.cpu_res_err = 1'b0;
`endif

    cpu_fabric_nibble_serdes #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W),
        .BW     (BW)
    ) u_serdes (
        .clk     (UserCLK),
        .rst_n   (resetn),
        .load    (accept),
        .shift   (shift),
        .capture (capture),
        .cap_idx (cap_idx),
        .publish (publish),
        .clear   (tmo),
        .a       (cpu.cpu_op_a),
        .b       (cpu.cpu_op_b),
        .res0    (RES0_I),
        .opa     (OPA_O),
        .opb     (OPB_O),
        .res     (cpu.cpu_res)
    );

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            beat              <= '0;
            flags_q           <= '0;
            cpu.cpu_op_ready  <= 1'b1;
            cpu.cpu_res_valid <= 1'b0;
            cpu.cpu_res_flags <= '0;
`ifdef CPU_FABRIC_TIMEOUT_EN
            tcnt              <= '0;
            err_q             <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state            <= SEND;
                        beat             <= '0;
                        cpu.cpu_op_ready <= 1'b0;
`ifdef CPU_FABRIC_TIMEOUT_EN
                        err_q            <= 1'b0;
`endif
                    end
                end
                SEND: begin
                    if (beat == LAST) begin
                        state <= WAIT;
                        beat  <= '0;
`ifdef CPU_FABRIC_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                WAIT: begin
                    if (strobe) begin
                        flags_q <= RES2_I;
                        beat    <= BW'(1);
                        state   <= RECV;
                    end
`ifdef CPU_FABRIC_TIMEOUT_EN
                    else if (tmo) begin
                        state             <= DONE;
                        cpu.cpu_res_valid <= 1'b1;
                        cpu.cpu_res_flags <= '0;
                        err_q             <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                RECV: begin
                    if (beat == LAST) begin
                        state             <= DONE;
                        cpu.cpu_res_valid <= 1'b1;
                        cpu.cpu_res_flags <= flags_q;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    // op_ready rises only after the result leaves.
                    if (cpu.cpu_res_ready) begin
                        state             <= IDLE;
                        cpu.cpu_res_valid <= 1'b0;
                        cpu.cpu_op_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fabric_io_bridge.sv
// Scoreboard bench: echo-fabric model plus random core traffic.
// Build with CPU_FABRIC_TIMEOUT_EN to exercise the WAIT timeout.
module tb_cpu_fabric_io_bridge;

`ifdef CPU_FABRIC_TIMEOUT_EN
    localparam int TMO = 16;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opa, opb, res0, res1, res2;

    cpu_fabric_io_bridge_if #(.DATA_W(32), .NIB_W(4)) cpu ();

    cpu_fabric_io_bridge #(
        .DATA_W(32), .NIB_W(4), .BEATS(8), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .UserCLK (clk),
        .resetn  (rst_n),
        .cpu     (cpu),
        .OPA_O   (opa),
        .OPB_O   (opb),
        .RES0_I  (res0),
        .RES1_I  (res1),
        .RES2_I  (res2)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          errs = 0;
    int          checks = 0;
    logic [31:0] last_res = '0;
    int          rdy_mode = 0;
    int          f_delay = 0;
    bit          f_flag_en = 0;
    logic [3:0]  f_flags = '0;
    bit          f_early = 0;
    bit          f_silent = 0;
    int          fab_beat = -1;
    int          fab_done = 0;
    bit          post_hs = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fab_clear();
        res0 = '0;
        res1 = '0;
        res2 = '0;
        fab_beat = -1;
    endtask

    // Fabric model: checks the serial operands and echoes A back.
    task automatic fabric_txn();
        logic [31:0] a, b;
        logic [3:0]  nib [8];
        logic [3:0]  fl;
        int          d;
        bit          early;
        exp_t        e;
        a = cpu.cpu_op_a;
        b = cpu.cpu_op_b;
        fl = f_flag_en ? f_flags : 4'($urandom);
        d = (f_delay > 0) ? f_delay : int'($urandom_range(1, 4));
        early = f_early || ($urandom_range(0, 3) == 0);
        e.res = f_silent ? 32'h0 : a;
        e.flags = f_silent ? 4'h0 : fl;
        e.err = f_silent;
        if (!f_silent || TMO_EN)
            sb.push_back(e);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!rst_n) begin fab_clear(); return; end
            nib[k] = opa;
            chk("opa_nibble", 32'(opa), 32'((a >> (4 * k)) & 32'hF));
            chk("opb_nibble", 32'(opb), 32'((b >> (4 * k)) & 32'hF));
            if (k == 0) begin
                chk("err_cleared", 32'(cpu.cpu_res_err), 0);
                chk("res_held", cpu.cpu_res, last_res);
            end
            if (early && k == 3) begin
                res1 = 4'h1;
                res0 = 4'($urandom);
            end
            if (k == 4) res1 = '0;
        end
        if (f_silent) begin
            if (TMO_EN) begin
                for (int w = 1; w <= TMO; w++) begin
                    @(negedge clk);
                    if (!rst_n) begin fab_clear(); return; end
                    if (w == 1) chk("opa_wait", 32'(opa), 0);
                    if (w == TMO) chk("tmo_not_early",
                                      32'(cpu.cpu_res_valid), 0);
                end
                @(negedge clk);
                chk("tmo_valid", 32'(cpu.cpu_res_valid), 1);
            end else begin
                repeat (40) @(negedge clk);
                chk("hang_valid", 32'(cpu.cpu_res_valid), 0);
                chk("hang_ready", 32'(cpu.cpu_op_ready), 0);
                chk("hang_err", 32'(cpu.cpu_res_err), 0);
            end
            fab_done++;
            return;
        end
        repeat (d - 1) begin
            @(negedge clk);
            if (!rst_n) begin fab_clear(); return; end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!rst_n) begin fab_clear(); return; end
            if (k == 0) chk("opa_idle", 32'(opa), 0);
            if (k == 7) chk("valid_early", 32'(cpu.cpu_res_valid), 0);
            fab_beat = k;
            res0 = nib[k];
            res1 = (k == 0) ? {3'($urandom), 1'b1} : 4'($urandom);
            res2 = (k == 0) ? fl : 4'($urandom);
        end
        @(negedge clk);
        fab_clear();
        if (!rst_n) return;
        chk("latency_valid", 32'(cpu.cpu_res_valid), 1);
        fab_done++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cpu.cpu_op_valid && cpu.cpu_op_ready)
                fabric_txn();
        end
    end

    // Monitor: compares every visible result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                post_hs = 0;
            end else begin
                if (post_hs) begin
                    chk("op_ready_after_hs", 32'(cpu.cpu_op_ready), 1);
                    post_hs = 0;
                end
                if (cpu.cpu_res_valid) begin
                    chk("no_overlap", 32'(cpu.cpu_op_ready), 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 32'(cpu.cpu_res_valid), 0);
                    end else begin
                        e = sb[0];
                        chk("res", cpu.cpu_res, e.res);
                        chk("flags", 32'(cpu.cpu_res_flags), 32'(e.flags));
                        chk("err", 32'(cpu.cpu_res_err), 32'(e.err));
                        if (cpu.cpu_res_ready) begin
                            void'(sb.pop_front());
                            last_res = e.res;
                            post_hs = 1;
                        end
                    end
                end
            end
        end
    end

    // Result back-pressure: 0 always ready, 1 random, 2 five cycles low.
    initial begin
        int dc = 0;
        cpu.cpu_res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dc = cpu.cpu_res_valid ? dc + 1 : 0;
            case (rdy_mode)
                1: cpu.cpu_res_ready = ($urandom_range(0, 2) != 0);
                2: cpu.cpu_res_ready = (dc > 5);
                default: cpu.cpu_res_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok = 0;
        cpu.cpu_op_valid = 1'b1;
        cpu.cpu_op_a = a;
        cpu.cpu_op_b = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu.cpu_op_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cpu.cpu_op_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && cpu.cpu_op_ready && fab_beat < 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_fab(input int target);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (fab_done >= target) begin ok = 1; break; end
        end
        if (!ok) chk("fabric_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        sb.delete();
        last_res = '0;
        chk("rst_valid", 32'(cpu.cpu_res_valid), 0);
        chk("rst_opa", 32'(opa), 0);
        chk("rst_opb", 32'(opb), 0);
        chk("rst_op_ready", 32'(cpu.cpu_op_ready), 1);
        chk("rst_flags", 32'(cpu.cpu_res_flags), 0);
        chk("rst_err", 32'(cpu.cpu_res_err), 0);
        chk("rst_res", cpu.cpu_res, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_op_ready", 32'(cpu.cpu_op_ready), 1);
    endtask

    initial begin
        bit ok;
        cpu.cpu_op_valid = 1'b0;
        cpu.cpu_op_a = '0;
        cpu.cpu_op_b = '0;
        fab_clear();
        rst_n = 1'b1;
        #2;
        pulse_reset();

        f_delay = 2;
        f_flag_en = 1;
        f_flags = 4'hA;
        send(32'h89ABCDEF, 32'h01234567);
        drain();
        f_delay = 0;
        f_flag_en = 0;

        rdy_mode = 2;
        send($urandom, $urandom);
        send($urandom, $urandom);
        drain();
        rdy_mode = 0;

        f_early = 1;
        send($urandom, $urandom);
        drain();
        f_early = 0;

        rdy_mode = 1;
        for (int i = 0; i < 25; i++) begin
            send($urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        rdy_mode = 0;

        send(32'h1, $urandom);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (fab_beat == 4) begin ok = 1; break; end
        end
        if (!ok) chk("recv_beat_timeout", 0, 1);
        pulse_reset();
        send(32'h1, $urandom);
        drain();

        f_silent = 1;
        send($urandom, $urandom);
        wait_fab(fab_done + 1);
        f_silent = 0;
        if (TMO_EN) drain();
        else pulse_reset();
        send($urandom, $urandom);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
